// File: rtl/counter_bus_slave_if.sv
// counter_bus_slave_if
//   Memory-mapped bus between a system master and the counter bus slave.
//   Word-addressed requests (busAddr[1:0] ignored), one-cycle handshake
//   through busWaitRequest, two-cycle read response through busReadValid,
//   plus the gated interrupt line returned to the system.
//
//   Signals:
//     busAddr        master->slave  byte address of the request
//     busWrite       master->slave  write request
//     busRead        master->slave  read request
//     busWriteData   master->slave  write data
//     busByteEn      master->slave  write byte enables, bit n covers data[8n+7:8n]
//     busWaitRequest slave->master  request not accepted this cycle
//     busReadData    slave->master  read data, meaningful with busReadValid
//     busReadValid   slave->master  one-cycle read response strobe
//     busIrq         slave->master  interrupt to system
interface counter_bus_slave_if #(
  parameter int unsigned ADDR_WIDTH = 4
) ();

  logic [ADDR_WIDTH-1:0] busAddr;
  logic                  busWrite;
  logic                  busRead;
  logic [31:0]           busWriteData;
  logic [3:0]            busByteEn;
  logic                  busWaitRequest;
  logic [31:0]           busReadData;
  logic                  busReadValid;
  logic                  busIrq;

  modport master (
    output busAddr,
    output busWrite,
    output busRead,
    output busWriteData,
    output busByteEn,
    input  busWaitRequest,
    input  busReadData,
    input  busReadValid,
    input  busIrq
  );

  modport slave (
    input  busAddr,
    input  busWrite,
    input  busRead,
    input  busWriteData,
    input  busByteEn,
    output busWaitRequest,
    output busReadData,
    output busReadValid,
    output busIrq
  );

endinterface

// File: rtl/counter_bus_slave.sv
// counter_bus_slave
//   Bus-side register interface for the counter peripheral core. Decodes bus
//   transactions into single-cycle core strobes and load values, returns read
//   data with a fixed two-cycle latency, and owns the sticky interrupt-pending
//   bit and the gated interrupt line.
//
//   Register map (busAddr[3:2], any higher address bit set = unmapped):
//     0 COUNT   RW  32-bit count
//     1 CONFIG  RW  bit0 En, bit1 Dir, bit2 Ire
//     2 STATUS      bit0 LT1000 (RO), bit1 IRQ_PEND (W1C)
//     3 unmapped: reads 0, writes ignored, transaction completes normally
//
//   Ports:
//     clk               clock, rising edge
//     reset             asynchronous active-low reset
//     bus               slave side of counter_bus_slave_if
//     counterIn         COUNT load value, valid during counterWe
//     counterEnIn/DirIn/IreIn  CONFIG load values, valid during counterConfigWe
//     counterWe, counterRe, counterConfigWe, counterConfigRe, counterStatusRe
//                       single-cycle core strobes
//     counterOut        core count
//     counterEnOut/DirOut/IreOut/LT1000Out  core config and status
//     counterIrq        core raw interrupt level
module counter_bus_slave #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_bus_slave_if.slave   bus,

  output logic [31:0]          counterIn,
  output logic                 counterEnIn,
  output logic                 counterDirIn,
  output logic                 counterIreIn,
  output logic                 counterWe,
  output logic                 counterRe,
  output logic                 counterConfigWe,
  output logic                 counterConfigRe,
  output logic                 counterStatusRe,

  input  logic [31:0]          counterOut,
  input  logic                 counterEnOut,
  input  logic                 counterDirOut,
  input  logic                 counterIreOut,
  input  logic                 counterLT1000Out,
  input  logic                 counterIrq
);

  typedef enum logic [1:0] {
    RegCount  = 2'd0,
    RegConfig = 2'd1,
    RegStatus = 2'd2,
    RegNone   = 2'd3
  } regSel_t;

  typedef enum logic [1:0] {
    StIdle,
    StRStrobe,
    StRResp
  } state_t;

  // Unmapped addresses collapse onto RegNone so the rest of the logic only
  // needs to look at a two-bit selector.
  function automatic regSel_t decodeReg(input logic [ADDR_WIDTH-1:0] addr);
    if ((addr >> 4) != '0) begin
      return RegNone;
    end
    return regSel_t'(addr[3:2]);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      stateQ, stateD;

  logic        wrValidQ;
  regSel_t     wrSelQ;
  logic [31:0] wrDataQ;
  logic [3:0]  wrBeQ;

  regSel_t     rdSelQ;
  logic [31:0] rdDataQ;

  logic        irqPendingQ, irqPendingD;
  logic        irqPrevQ;

  // ---------------------------------------------------------------------------
  // Request acceptance
  // ---------------------------------------------------------------------------
  logic        waitRequest;
  logic        reqAccept;
  logic        wrAccept;
  logic        rdAccept;
  regSel_t     reqSel;

  always_comb begin
    waitRequest = (stateQ == StRStrobe);
    reqAccept   = (bus.busWrite | bus.busRead) & ~waitRequest;
    // A simultaneous write wins; the read half is silently dropped.
    wrAccept    = reqAccept & bus.busWrite;
    rdAccept    = reqAccept & bus.busRead & ~bus.busWrite;
    reqSel      = decodeReg(bus.busAddr);
  end

  // ---------------------------------------------------------------------------
  // Write path: one pipeline register, strobe in the following cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrValidQ <= 1'b0;
      wrSelQ   <= RegNone;
      wrDataQ  <= '0;
      wrBeQ    <= '0;
    end else begin
      wrValidQ <= wrAccept;
      if (wrAccept) begin
        wrSelQ  <= reqSel;
        wrDataQ <= bus.busWriteData;
        wrBeQ   <= bus.busByteEn;
      end
    end
  end

  logic statusClear;

  always_comb begin
    counterWe       = wrValidQ & (wrSelQ == RegCount);
    counterConfigWe = wrValidQ & (wrSelQ == RegConfig) & wrBeQ[0];
    statusClear     = wrValidQ & (wrSelQ == RegStatus) & wrBeQ[0] & wrDataQ[1];

    // Unselected bytes follow the live core count so a partial write never
    // disturbs bytes the core may be changing in the same cycle.
    counterIn = '0;
    if (counterWe) begin
      for (int b = 0; b < 4; b++) begin
        counterIn[8*b +: 8] = wrBeQ[b] ? wrDataQ[8*b +: 8] : counterOut[8*b +: 8];
      end
    end

    counterEnIn  = counterConfigWe & wrDataQ[0];
    counterDirIn = counterConfigWe & wrDataQ[1];
    counterIreIn = counterConfigWe & wrDataQ[2];
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  logic [31:0] rdMux;

  always_comb begin
    unique case (rdSelQ)
      RegCount:  rdMux = counterOut;
      RegConfig: rdMux = {29'd0, counterIreOut, counterDirOut, counterEnOut};
      RegStatus: rdMux = {30'd0, irqPendingQ, counterLT1000Out};
      default:   rdMux = '0;
    endcase
  end

  always_comb begin
    stateD          = stateQ;
    counterRe       = 1'b0;
    counterConfigRe = 1'b0;
    counterStatusRe = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (rdAccept) begin
          stateD = StRStrobe;
        end
      end
      StRStrobe: begin
        stateD          = StRResp;
        counterRe       = (rdSelQ == RegCount);
        counterConfigRe = (rdSelQ == RegConfig);
        counterStatusRe = (rdSelQ == RegStatus);
      end
      StRResp: begin
        // Wait request is low here, so a follow-on read can be taken at once.
        stateD = rdAccept ? StRStrobe : StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= StIdle;
      rdSelQ  <= RegNone;
      rdDataQ <= '0;
    end else begin
      stateQ <= stateD;
      if (rdAccept) begin
        rdSelQ <= reqSel;
      end
      // Capture at the end of the strobe cycle so a write strobed one cycle
      // earlier is already visible in the core outputs.
      if (stateQ == StRStrobe) begin
        rdDataQ <= rdMux;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt pending
  // ---------------------------------------------------------------------------
  logic irqSet;

  always_comb begin
    irqSet = counterIrq & ~irqPrevQ;
    // Set dominates a same-cycle W1C so no edge is ever lost.
    irqPendingD = irqSet | (irqPendingQ & ~statusClear);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irqPendingQ <= 1'b0;
      irqPrevQ    <= 1'b0;
    end else begin
      irqPendingQ <= irqPendingD;
      irqPrevQ    <= counterIrq;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus outputs
  // ---------------------------------------------------------------------------
  assign bus.busWaitRequest = waitRequest;
  assign bus.busReadValid   = (stateQ == StRResp);
  assign bus.busReadData    = (stateQ == StRResp) ? rdDataQ : '0;
  assign bus.busIrq         = irqPendingQ & counterIreOut;

endmodule

// File: tb/tb_counter_bus_slave.sv
module tb_counter_bus_slave;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  counter_bus_slave_if #(.ADDR_WIDTH(4)) bus ();

  logic [31:0] counterIn;
  logic        counterEnIn, counterDirIn, counterIreIn;
  logic        counterWe, counterRe, counterConfigWe, counterConfigRe, counterStatusRe;

  // Minimal behavioural core: loadable up/down counter, irq level at 0xFFFF.
  logic [31:0] coreCount;
  logic        coreEn, coreDir, coreIre;
  logic        coreIrq, coreLt1000;

  assign coreIrq    = coreIre & (coreCount == 32'h0000_FFFF);
  assign coreLt1000 = (coreCount < 32'd1000);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      coreCount <= '0;
      coreEn    <= 1'b0;
      coreDir   <= 1'b0;
      coreIre   <= 1'b0;
    end else begin
      if (counterWe) coreCount <= counterIn;
      else if (coreEn) coreCount <= coreDir ? coreCount + 32'd1 : coreCount - 32'd1;
      if (counterConfigWe) begin
        coreEn  <= counterEnIn;
        coreDir <= counterDirIn;
        coreIre <= counterIreIn;
      end
    end
  end

  counter_bus_slave #(.ADDR_WIDTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .counterIn        (counterIn),
    .counterEnIn      (counterEnIn),
    .counterDirIn     (counterDirIn),
    .counterIreIn     (counterIreIn),
    .counterWe        (counterWe),
    .counterRe        (counterRe),
    .counterConfigWe  (counterConfigWe),
    .counterConfigRe  (counterConfigRe),
    .counterStatusRe  (counterStatusRe),
    .counterOut       (coreCount),
    .counterEnOut     (coreEn),
    .counterDirOut    (coreDir),
    .counterIreOut    (coreIre),
    .counterLT1000Out (coreLt1000),
    .counterIrq       (coreIrq)
  );

  int checkCount = 0;
  int errCount   = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rdStrobes();
    return {counterRe, counterConfigRe, counterStatusRe};
  endfunction

  function automatic logic [1:0] wrStrobes();
    return {counterWe, counterConfigWe};
  endfunction

  task automatic checkOutputsZero(input string pfx);
    checkEq({pfx, ".wait"},  32'(bus.busWaitRequest), 32'd0);
    checkEq({pfx, ".valid"}, 32'(bus.busReadValid), 32'd0);
    checkEq({pfx, ".rdata"}, bus.busReadData, 32'd0);
    checkEq({pfx, ".irq"},   32'(bus.busIrq), 32'd0);
    checkEq({pfx, ".rstb"},  32'(rdStrobes()), 32'd0);
    checkEq({pfx, ".wstb"},  32'(wrStrobes()), 32'd0);
    checkEq({pfx, ".cin"},   counterIn, 32'd0);
    checkEq({pfx, ".cfgin"}, 32'({counterIreIn, counterDirIn, counterEnIn}), 32'd0);
  endtask

  // Returns in cycle A+1 (the strobe cycle).
  task automatic writeReg(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.busAddr      = addr;
    bus.busWriteData = data;
    bus.busByteEn    = be;
    bus.busWrite     = 1'b1;
    step();
    bus.busWrite  = 1'b0;
    bus.busByteEn = 4'h0;
  endtask

  // expStb is {counterRe, counterConfigRe, counterStatusRe}; returns in A+3.
  task automatic readReg(input string tag, input logic [3:0] addr, input logic [2:0] expStb,
                         input logic [31:0] expData);
    bus.busAddr = addr;
    bus.busRead = 1'b1;
    step();
    bus.busRead = 1'b0;
    checkEq({tag, ".wait"},  32'(bus.busWaitRequest), 32'd1);
    checkEq({tag, ".stb"},   32'(rdStrobes()), 32'(expStb));
    checkEq({tag, ".vld1"},  32'(bus.busReadValid), 32'd0);
    step();
    checkEq({tag, ".vld2"},  32'(bus.busReadValid), 32'd1);
    checkEq({tag, ".data"},  bus.busReadData, expData);
    checkEq({tag, ".wait2"}, 32'(bus.busWaitRequest), 32'd0);
    step();
    checkEq({tag, ".vld3"},  32'(bus.busReadValid), 32'd0);
  endtask

  initial begin
    bus.busAddr      = '0;
    bus.busWrite     = 1'b0;
    bus.busRead      = 1'b0;
    bus.busWriteData = '0;
    bus.busByteEn    = '0;

    // Reset state
    #2;
    checkOutputsZero("rst");
    step();
    step();
    #2;
    reset = 1'b1;
    step();

    // 1: full COUNT write and read-back
    writeReg(4'h0, 32'h0000_1234, 4'hF);
    checkEq("t1.we",  32'(wrStrobes()), 32'h2);
    checkEq("t1.cin", counterIn, 32'h0000_1234);
    step();
    checkEq("t1.we1cyc", 32'(wrStrobes()), 32'h0);
    readReg("t1.rd", 4'h0, 3'b100, 32'h0000_1234);

    // Unmapped address: no strobes, reads 0
    readReg("um.rd", 4'hC, 3'b000, 32'h0);
    writeReg(4'hC, 32'hFFFF_FFFF, 4'hF);
    checkEq("um.wstb", 32'(wrStrobes()), 32'h0);
    step();

    // 2: byte-merged COUNT write against the live count
    writeReg(4'h0, 32'h1122_3344, 4'hF);
    step();
    writeReg(4'h0, 32'h0000_AB00, 4'h2);
    checkEq("t2.we",  32'(counterWe), 32'd1);
    checkEq("t2.cin", counterIn, 32'h1122_AB44);
    step();
    readReg("t2.rd", 4'h0, 3'b100, 32'h1122_AB44);

    // 3: CONFIG write, read-back, and byteEn[0]=0 suppresses the strobe
    writeReg(4'h4, 32'h0000_0007, 4'h1);
    checkEq("t3.cfgwe", 32'(wrStrobes()), 32'h1);
    checkEq("t3.cfgin", 32'({counterIreIn, counterDirIn, counterEnIn}), 32'h7);
    step();
    readReg("t3.rd", 4'h4, 3'b010, 32'h0000_0007);
    writeReg(4'h4, 32'h0000_0000, 4'hF);
    step();
    writeReg(4'h4, 32'h0000_0007, 4'hE);
    checkEq("t3.nostb", 32'(wrStrobes()), 32'h0);
    step();
    readReg("t3.rd0", 4'h4, 3'b010, 32'h0);

    // 4: interrupt edge, pending, gated line, W1C
    writeReg(4'h0, 32'h0000_FFFE, 4'hF);
    step();
    writeReg(4'h4, 32'h0000_0007, 4'hF);
    checkEq("t4.irq0", 32'(bus.busIrq), 32'd0);
    step();
    step();
    step();
    checkEq("t4.irq1", 32'(bus.busIrq), 32'd1);
    readReg("t4.st", 4'h8, 3'b001, 32'h0000_0002);
    writeReg(4'h8, 32'h0000_0002, 4'h1);
    checkEq("t4.irqA1", 32'(bus.busIrq), 32'd1);
    step();
    checkEq("t4.irqA2", 32'(bus.busIrq), 32'd0);
    writeReg(4'h4, 32'h0000_0000, 4'hF);
    step();
    readReg("t4.st0", 4'h8, 3'b001, 32'h0);
    writeReg(4'h0, 32'h0000_0005, 4'hF);
    step();
    readReg("t4.lt", 4'h8, 3'b001, 32'h0000_0001);

    // 5: back-to-back reads COUNT then STATUS
    bus.busAddr = 4'h0;
    bus.busRead = 1'b1;
    step();
    bus.busAddr = 4'h8;
    checkEq("t5.w1",   32'(bus.busWaitRequest), 32'd1);
    checkEq("t5.stb1", 32'(rdStrobes()), 32'h4);
    step();
    checkEq("t5.w2",   32'(bus.busWaitRequest), 32'd0);
    checkEq("t5.v2",   32'(bus.busReadValid), 32'd1);
    checkEq("t5.d2",   bus.busReadData, 32'h0000_0005);
    step();
    bus.busRead = 1'b0;
    checkEq("t5.w3",   32'(bus.busWaitRequest), 32'd1);
    checkEq("t5.v3",   32'(bus.busReadValid), 32'd0);
    checkEq("t5.stb3", 32'(rdStrobes()), 32'h1);
    step();
    checkEq("t5.w4",   32'(bus.busWaitRequest), 32'd0);
    checkEq("t5.v4",   32'(bus.busReadValid), 32'd1);
    checkEq("t5.d4",   bus.busReadData, 32'h0000_0001);
    step();
    checkEq("t5.v5",   32'(bus.busReadValid), 32'd0);

    // 5b: read and write together -> write only
    bus.busAddr      = 4'h0;
    bus.busWriteData = 32'h0000_0077;
    bus.busByteEn    = 4'hF;
    bus.busWrite     = 1'b1;
    bus.busRead      = 1'b1;
    step();
    bus.busWrite = 1'b0;
    bus.busRead  = 1'b0;
    checkEq("t5b.we",   32'(counterWe), 32'd1);
    checkEq("t5b.rstb", 32'(rdStrobes()), 32'h0);
    checkEq("t5b.wait", 32'(bus.busWaitRequest), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkEq("t5b.novld", 32'(bus.busReadValid), 32'd0);
    end
    readReg("t5b.rd", 4'h0, 3'b100, 32'h0000_0077);

    // 6: reset during RSTROBE
    bus.busAddr = 4'h8;
    bus.busRead = 1'b1;
    step();
    bus.busRead = 1'b0;
    checkEq("t6.pre", 32'(bus.busWaitRequest), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutputsZero("t6.rst");
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkEq("t6.novld", 32'(bus.busReadValid), 32'd0);
      checkEq("t6.nowait", 32'(bus.busWaitRequest), 32'd0);
    end
    readReg("t6.rd", 4'h0, 3'b100, 32'h0);
    writeReg(4'h0, 32'hCAFE_F00D, 4'hF);
    step();
    readReg("t6.rd2", 4'h0, 3'b100, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/counter_bus_slave.md
Name: counter_bus_slave

Overview:
Bus-side register interface for the counter peripheral core. It sits directly upstream of the core. It decodes simple memory-mapped bus transactions into the core's write/read strobes and input data, and returns read data. It also owns the sticky interrupt-pending bit and the gated interrupt line to the system.

Parameters:
ADDR_WIDTH, 4, byte-address width of busAddr; bits [1:0] ignored (word access only).

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
busAddr  input  ADDR_WIDTH  byte address of request.
busWrite  input  1  write request.
busRead  input  1  read request.
busWriteData  input  32  write data.
busByteEn  input  4  byte enables for writes; bit n covers data[8n+7:8n].
busWaitRequest  output  1  high = request not accepted this cycle.
busReadData  output  32  read data, valid only with busReadValid.
busReadValid  output  1  one-cycle read response strobe.
busIrq  output  1  interrupt to system.
counterIn  output  32  count load value to core.
counterEnIn / counterDirIn / counterIreIn  output  1 each  config load values to core.
counterWe / counterRe / counterConfigWe / counterConfigRe / counterStatusRe  output  1 each  single-cycle core strobes.
counterOut  input  32  core count.
counterEnOut / counterDirOut / counterIreOut / counterLT1000Out  input  1 each  core config and status.
counterIrq  input  1  core raw interrupt (level).

Behaviour:
- Reset (reset=0) clears every register and drives every output to 0 immediately. This includes busWaitRequest, busReadValid, all strobes, and irqPending. The irq edge register also resets to 0.
- Register map (addr[3:2]):
  - 0 = COUNT: RW, full 32 bits.
  - 1 = CONFIG: RW; bit0 En, bit1 Dir, bit2 Ire; other bits read 0.
  - 2 = STATUS: bit0 LT1000 (RO), bit1 IRQ_PEND (W1C).
  - 3 and any address with bits above [3:2] nonzero: reads return 0, writes are ignored, and the transaction still completes normally.
- Acceptance: a request is accepted in a cycle where (busWrite|busRead) and !busWaitRequest.
- If busWrite and busRead are both high, the write is accepted. The read is dropped with no busReadValid.
- Write accepted in cycle A: address, data and byte enables are registered. In A+1 exactly one target strobe pulses for one cycle (counterWe or counterConfigWe), or the W1C action occurs. No wait state applies, so back-to-back writes are pipelined one per cycle.
- COUNT write: counterIn during the strobe cycle is combinational. Bytes with byteEn=1 come from the registered data; bytes with byteEn=0 come from the live counterOut. This keeps unselected bytes exact even while the core counts.
- CONFIG write: strobe only if byteEn[0]=1. En, Dir and Ire are taken from data[2:0].
- STATUS write: if byteEn[0]=1 and data[1]=1, clear irqPending at the end of A+1.
- Read FSM states:
  - IDLE: on read accept in A, go to RSTROBE.
  - RSTROBE (cycle A+1): busWaitRequest=1. Pulse exactly one of counterRe, counterConfigRe or counterStatusRe according to address (none for unmapped). Capture read data at the end of the cycle from core outputs and irqPending. Go to RRESP.
  - RRESP (cycle A+2): busReadValid=1 with busReadData. busWaitRequest=0, so a new request may be accepted this cycle. Next state is RSTROBE if a read is accepted, else IDLE.
- Read latency is 2 cycles, and at most one read is outstanding. A write accepted in RRESP or IDLE proceeds as above.
- Write followed by read of the same register: the read returns the newly written value (strobe A+1, core update end of A+1, capture end of A+2).
- busWaitRequest is high only in RSTROBE.
- Interrupt pending:
  - irqPending sets on a rising edge of counterIrq (counterIrq=1 and previous sample 0).
  - If a set and a W1C clear occur in the same cycle, set wins.
  - Remains set until cleared.
  - busIrq = irqPending & counterIreOut, combinational from registers.
- Reset mid-transaction: a pending strobe or read response is abandoned and never issued after reset release. The FSM returns to IDLE.

Test Plan:
1. Write COUNT 0x0000_1234 with byteEn=0xF, counter disabled → counterWe=1 for one cycle at A+1 with counterIn=0x0000_1234. Read COUNT → busReadValid at A+2 with data 0x0000_1234.
2. counterOut=0x1122_3344, write COUNT 0x0000_AB00 with byteEn=0x2 → counterIn=0x1122_AB44 in the strobe cycle.
3. Write CONFIG 0x7 → counterConfigWe pulse with En=Dir=Ire=1. Read CONFIG → 0x0000_0007. A CONFIG write with byteEn=0xE → no strobe.
4. Load COUNT 0x0000_FFFE, then CONFIG 0x7 → counterIrq rises at count 0xFFFF; irqPending=1; busIrq=1; STATUS read bit1=1. Write STATUS 0x2 → busIrq=0 from A+2 onward.
5. Back-to-back reads of COUNT and STATUS → busWaitRequest high exactly one cycle per read, and the second response arrives 2 cycles after the first. busRead and busWrite high together to COUNT → counterWe pulses, with no counterRe and no busReadValid.
6. Assert reset during RSTROBE → all outputs 0 immediately. busReadValid is never asserted after release. The next read completes normally with 2-cycle latency.
